pc_sequencer: RTL and testbench

- Sequences the single-cycle picoMIPS datapath: owns the program counter, resolves branches, and stalls execution on hold instructions until the user presses and releases SW[8].
- Debounces and synchronises the raw SW[8] input internally.
- Gates the register-file write enable so nothing is written while stalled.
- Sits between the decoder/prog_mem fields and the prog_mem address, and replaces the bare program counter.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer_if : decoder/prog_mem fields in, PC and gated controls out.
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int PC_W = 5
);
  logic            sw8;
  logic            bran;
  logic            is_hold;
  logic            condition;
  logic            zero_flag;
  logic [PC_W-1:0] target;
  logic            we_in;
  logic            step_mode;
  logic [PC_W-1:0] pc;
  logic            we_out;
  logic            stalled;
  logic            sw8_db;

  modport master (
    output sw8, bran, is_hold, condition, zero_flag, target, we_in, step_mode,
    input  pc, we_out, stalled, sw8_db
  );

  modport slave (
    input  sw8, bran, is_hold, condition, zero_flag, target, we_in, step_mode,
    output pc, we_out, stalled, sw8_db
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer : picoMIPS PC, branch resolution and SW[8] hold/step stalls.
// Optional single-step mode enabled by macro PC_SEQ_STEP_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PC_W       = 5,
  parameter int DEB_CYCLES = 16,
  parameter int RESET_PC   = 0
) (
  input  logic         clk,
  input  logic         rst,
  pc_sequencer_if.slave bus
);

  localparam int C_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN          = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_WAIT_RELEASE = 2'd2
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db;
  logic [C_CNT_W-1:0] r_cnt;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_run_target;
  logic [PC_W-1:0]    w_resume_pc;
  logic               w_hold;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_hold   = bus.bran & bus.is_hold;

  // Non-hold next address; a failed conditional jump falls through.
  assign w_run_target = (!bus.bran || (bus.condition && !bus.zero_flag)) ?
                        w_pc_inc : bus.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_state <= S_RUN;
      r_pc    <= PC_W'(RESET_PC);
    end else begin
      r_sync1 <= bus.sw8;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef PC_SEQ_STEP_EN
  logic [PC_W-1:0] r_next_pc;
  logic            w_step;

  // Tracks the successor of every RUN instruction, so a hold resumes at pc+1
  // and a stepped instruction resumes at its own computed next address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_pc <= PC_W'(RESET_PC);
    end else if (r_state == S_RUN) begin
      r_next_pc <= w_hold ? w_pc_inc : w_run_target;
    end
  end

  assign w_step      = bus.step_mode;
  assign w_resume_pc = r_next_pc;
`else
  logic w_step;
  logic unused_step_mode;

  assign unused_step_mode = bus.step_mode;
  assign w_step           = 1'b0;
  assign w_resume_pc      = w_pc_inc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_RUN: begin
        if (w_hold || w_step) begin
          w_state_nxt = S_WAIT_PRESS;
        end else begin
          w_pc_nxt = w_run_target;
        end
      end
      S_WAIT_PRESS: begin
        if (r_db) begin
          w_state_nxt = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!r_db) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_resume_pc;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign bus.pc      = r_pc;
  assign bus.we_out  = bus.we_in & (r_state == S_RUN) & ~w_hold;
  assign bus.stalled = (r_state != S_RUN);
  assign bus.sw8_db  = r_db;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_sequencer : vector table plus hold, reset and step sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int PC_W = 5;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W       (PC_W),
    .DEB_CYCLES (DEB),
    .RESET_PC   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            bran;
    logic            is_hold;
    logic            condition;
    logic            zero_flag;
    logic [PC_W-1:0] target;
    logic            we_in;
    logic            exp_we;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  vec_t            vecs[12];
  logic [PC_W-1:0] sb_q[$];
  int              vectors     = 0;
  int              miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic h, input logic c, input logic z,
                       input logic [PC_W-1:0] t, input logic w);
    bus.bran      = b;
    bus.is_hold   = h;
    bus.condition = c;
    bus.zero_flag = z;
    bus.target    = t;
    bus.we_in     = w;
  endtask

  // Counts edges until sw8_db reaches lvl, giving up after max edges.
  task automatic wait_db(input logic lvl, input int max, output int n);
    n = 0;
    while (bus.sw8_db !== lvl && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [PC_W-1:0] exp_pc;

    //            bran hold cond zf  tgt we  exp_we exp_pc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd3};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 5'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 5'd31};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 5'd7};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 5'd12};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1, 5'd13};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 5'd13};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd14};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 5'd5};

    bus.sw8       = 1'b0;
    bus.step_mode = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_pc", bus.pc, 0);
    check("reset_stalled", bus.stalled, 0);
    check("reset_sw8_db", bus.sw8_db, 0);
    bus.we_in = 1'b1;
    #1;
    check("reset_we_follow", bus.we_out, 1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].bran, vecs[i].is_hold, vecs[i].condition, vecs[i].zero_flag,
            vecs[i].target, vecs[i].we_in);
      #1;
      check($sformatf("vec%0d_we", i), bus.we_out, vecs[i].exp_we);
      check($sformatf("vec%0d_stalled", i), bus.stalled, 0);
      sb_q.push_back(vecs[i].exp_pc);
      tick();
      exp_pc = sb_q.pop_front();
      check($sformatf("vec%0d_pc", i), bus.pc, exp_pc);
    end

    // Hold at pc=5, glitch rejection, then a full press/release.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    #1;
    check("hold_we_run", bus.we_out, 0);
    tick();
    check("hold_pc", bus.pc, 5);
    check("hold_stalled", bus.stalled, 1);
    check("hold_we", bus.we_out, 0);
    bus.sw8 = 1'b1;
    repeat (3) tick();
    bus.sw8 = 1'b0;
    repeat (10) tick();
    check("glitch_db", bus.sw8_db, 0);
    check("glitch_stalled", bus.stalled, 1);
    check("glitch_pc", bus.pc, 5);
    bus.sw8 = 1'b1;
    wait_db(1'b1, 20, n);
    check("press_latency", n, 6);
    repeat (4) tick();
    check("press_pc", bus.pc, 5);
    check("press_stalled", bus.stalled, 1);
    bus.sw8 = 1'b0;
    wait_db(1'b0, 20, n);
    check("release_latency", n, 6);
    check("release_pc_held", bus.pc, 5);
    check("release_stalled", bus.stalled, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    check("resume_pc", bus.pc, 6);
    check("resume_stalled", bus.stalled, 0);
    check("resume_we", bus.we_out, 1);

    // Reset while in WAIT_RELEASE at pc=9.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
    tick();
    check("jump9_pc", bus.pc, 9);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    bus.sw8 = 1'b1;
    wait_db(1'b1, 20, n);
    check("rst_press_latency", n, 6);
    tick();
    check("rst_pre_pc", bus.pc, 9);
    check("rst_pre_stalled", bus.stalled, 1);
    rst     = 1'b1;
    bus.sw8 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    rst = 1'b0;
    check("midrst_pc", bus.pc, 0);
    check("midrst_stalled", bus.stalled, 0);
    check("midrst_db", bus.sw8_db, 0);
    check("midrst_we", bus.we_out, 1);
    tick();
    check("midrst_run_pc", bus.pc, 1);
    tick();
    check("pre_step_pc", bus.pc, 2);

`ifdef PC_SEQ_STEP_EN
    bus.step_mode = 1'b1;
    bus.we_in     = 1'b1;
    #1;
    check("step_we_run", bus.we_out, 1);
    tick();
    bus.step_mode = 1'b0;
    check("step_pc_held", bus.pc, 2);
    check("step_stalled", bus.stalled, 1);
    check("step_we_stall", bus.we_out, 0);
    bus.sw8 = 1'b1;
    wait_db(1'b1, 20, n);
    check("step_press", n, 6);
    tick();
    bus.sw8 = 1'b0;
    wait_db(1'b0, 20, n);
    check("step_release", n, 6);
    tick();
    check("step_resume_pc", bus.pc, 3);
    check("step_resume_stalled", bus.stalled, 0);
`else
    bus.step_mode = 1'b1;
    #1;
    check("nostep_we", bus.we_out, 1);
    tick();
    check("nostep_pc", bus.pc, 3);
    check("nostep_stalled", bus.stalled, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
